// File: rtl/idct8_mac_ts.sv
// idct8_mac_ts: 8-point IDCT using one time-shared multiplier and accumulator, 64 MAC cycles per vector.
// Define IDCT8_SAT_EN to clamp results to the IN_W range instead of wrapping them.
module idct8_mac_ts #(
    parameter int IN_W    = 32,
    parameter int CONST_W = 14,
    parameter int FRAC    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in0,
    input  logic signed [IN_W-1:0] in1,
    input  logic signed [IN_W-1:0] in2,
    input  logic signed [IN_W-1:0] in3,
    input  logic signed [IN_W-1:0] in4,
    input  logic signed [IN_W-1:0] in5,
    input  logic signed [IN_W-1:0] in6,
    input  logic signed [IN_W-1:0] in7,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [IN_W-1:0] out0,
    output logic signed [IN_W-1:0] out1,
    output logic signed [IN_W-1:0] out2,
    output logic signed [IN_W-1:0] out3,
    output logic signed [IN_W-1:0] out4,
    output logic signed [IN_W-1:0] out5,
    output logic signed [IN_W-1:0] out6,
    output logic signed [IN_W-1:0] out7
);
    localparam int ACC_W = IN_W + CONST_W + 3;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << (CONST_W - 2));
    // Row n, column k: C[n][k] scaled by 2^13
    localparam int C_TAB [64] = '{
        2896,  4017,  3784,  3406,  2896,  2276,  1567,   799,
        2896,  3406,  1567,  -799, -2896, -4017, -3784, -2276,
        2896,  2276, -1567, -4017, -2896,   799,  3784,  3406,
        2896,   799, -3784, -2276,  2896,  3406, -1567, -4017,
        2896,  -799, -3784,  2276,  2896, -3406, -1567,  4017,
        2896, -2276, -1567,  4017, -2896,  -799,  3784, -3406,
        2896, -3406,  1567,   799, -2896,  4017, -3784,  2276,
        2896, -4017,  3784, -3406,  2896, -2276,  1567,  -799
    };

    if (FRAC < 0 || FRAC >= IN_W) begin : g_frac_chk
        $error("FRAC must lie in [0, IN_W)");
    end

    typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_t;
    state_t state, state_nx;

    logic [5:0]                     cnt;
    logic signed [IN_W-1:0]         x_reg [8];
    logic signed [IN_W-1:0]         y_reg [8];
    logic signed [CONST_W-1:0]      coef;
    logic signed [IN_W+CONST_W-1:0] prod;
    logic signed [ACC_W-1:0]        acc, acc_sum;
    logic signed [IN_W-1:0]         res;

    assign coef    = CONST_W'(C_TAB[cnt]);
    assign prod    = x_reg[cnt[2:0]] * coef;
    assign acc_sum = acc + ACC_W'(prod);

`ifdef IDCT8_SAT_EN
    logic signed [ACC_W-1:0] rnd;
    assign rnd = (acc_sum + HALF) >>> (CONST_W - 1);
    assign res = (&rnd[ACC_W-1:IN_W-1] || ~|rnd[ACC_W-1:IN_W-1]) ? rnd[IN_W-1:0]
               : {rnd[ACC_W-1], {(IN_W-1){~rnd[ACC_W-1]}}};
`else
    assign res = IN_W'((acc_sum + HALF) >>> (CONST_W - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? COMPUTE : IDLE;
            COMPUTE: state_nx = (cnt == 6'd63) ? HOLD : COMPUTE;
            HOLD:    state_nx = out_ready ? IDLE : HOLD;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == HOLD) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
            for (int i = 0; i < 8; i++) y_reg[i] <= '0;
        end else begin
            if (in_valid && in_ready) begin
                x_reg <= '{in0, in1, in2, in3, in4, in5, in6, in7};
                cnt   <= '0;
                acc   <= '0;
            end
            if (state == COMPUTE) begin
                cnt <= cnt + 6'd1;
                acc <= (&cnt[2:0]) ? '0 : acc_sum;
                if (&cnt[2:0]) y_reg[cnt[5:3]] <= res;
            end
        end
    end

    assign out0 = y_reg[0];
    assign out1 = y_reg[1];
    assign out2 = y_reg[2];
    assign out3 = y_reg[3];
    assign out4 = y_reg[4];
    assign out5 = y_reg[5];
    assign out6 = y_reg[6];
    assign out7 = y_reg[7];
endmodule

// File: tb/tb_idct8_mac_ts.sv
// tb_idct8_mac_ts: randomized bench for idct8_mac_ts against a floating-point-derived IDCT model.
// Expectations follow IDCT8_SAT_EN the same way the design does.
module tb_idct8_mac_ts;
    typedef logic signed [31:0] vec_t [8];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid;
    vec_t din;
    vec_t dout;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    idct8_mac_ts dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(dout[0]), .out1(dout[1]), .out2(dout[2]), .out3(dout[3]),
        .out4(dout[4]), .out5(dout[5]), .out6(dout[6]), .out7(dout[7])
    );

    function automatic longint cval(int n, int k);
        real a, v;
        a = (k == 0) ? $sqrt(0.125) : 0.5;
        v = a * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0) * 8192.0;
        return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(0.5 - v));
    endfunction

    function automatic vec_t ref_idct(vec_t x);
        vec_t y;
        longint s, r;
        for (int n = 0; n < 8; n++) begin
            s = 0;
            for (int k = 0; k < 8; k++) s += cval(n, k) * longint'(x[k]);
            r = (s + 64'sd4096) >>> 13;
`ifdef IDCT8_SAT_EN
            y[n] = (r > 64'sd2147483647) ? 32'sh7FFFFFFF :
                   (r < -64'sd2147483648) ? 32'sh80000000 : 32'(r);
`else
            y[n] = 32'(r);
`endif
        end
        return y;
    endfunction

    function automatic vec_t rand_vec(bit full);
        vec_t x;
        for (int k = 0; k < 8; k++)
            x[k] = full ? 32'($urandom()) : 32'(int'($urandom_range(0, 131071)) - 65536);
        return x;
    endfunction

    function automatic vec_t dc_vec(int v);
        vec_t x;
        for (int k = 0; k < 8; k++) x[k] = (k == 0) ? 32'(v) : 32'sd0;
        return x;
    endfunction

    // Accepts x, waits for out_valid, checks latency and the 8 samples; leaves the block in HOLD.
    task automatic run_vec(input vec_t x, input bit churn, input string name);
        vec_t exp_y;
        int lat, w;
        exp_y = ref_idct(x);
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready_timeout: in_ready=%b required 1", name, in_ready);
        end
        din = x;
        in_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid) begin
                in_valid = churn;
                if (churn) din = rand_vec(1'b1);
                out_ready = churn ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end while (!out_valid && lat < 200);
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (lat !== 65) begin
            n_bad++;
            $display("FAIL %s latency: got %0d cycles required 65", name, lat);
        end
        for (int n = 0; n < 8; n++) begin
            n_cmp++;
            if (dout[n] !== exp_y[n]) begin
                n_bad++;
                $display("FAIL %s out%0d: got %0d required %0d", name, n, dout[n], exp_y[n]);
            end
        end
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s release: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        din = dc_vec(0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 0/0", in_ready, out_valid);
        end
        for (int n = 0; n < 8; n++) begin
            n_cmp++;
            if (dout[n] !== 32'sd0) begin
                n_bad++;
                $display("FAIL reset_out%0d: got %0d required 0", n, dout[n]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_dc();
        run_vec(dc_vec(256), 1'b0, "dc_pos");
        for (int n = 0; n < 8; n++) begin
            n_cmp++;
            if (dout[n] !== 32'sd91) begin
                n_bad++;
                $display("FAIL dc_pos_const out%0d: got %0d required 91", n, dout[n]);
            end
        end
        consume("dc_pos");
        run_vec(dc_vec(-256), 1'b0, "dc_neg");
        for (int n = 0; n < 8; n++) begin
            n_cmp++;
            if (dout[n] !== -32'sd90) begin
                n_bad++;
                $display("FAIL dc_neg_const out%0d: got %0d required -90", n, dout[n]);
            end
        end
        consume("dc_neg");
        run_vec(dc_vec(0), 1'b0, "zero");
        consume("zero");
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            run_vec(rand_vec(t[0]), 1'b0, $sformatf("rand%0d", t));
            consume($sformatf("rand%0d", t));
        end
    endtask

    task automatic test_backpressure();
        vec_t held;
        bit bad;
        run_vec(rand_vec(1'b0), 1'b0, "bp");
        held = dout;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || dout !== held) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL bp_hold: out_valid=%b in_ready=%b out0=%0d held out0=%0d", out_valid, in_ready, dout[0], held[0]);
        end
        consume("bp");
    endtask

    task automatic test_reset_mid();
        bit rose;
        din = rand_vec(1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || dout[0] !== 32'sd0) begin
            n_bad++;
            $display("FAIL mid_rst_state: in_ready=%b out_valid=%b out0=%0d required 0/0/0", in_ready, out_valid, dout[0]);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_rst_ready: in_ready=%b required 1", in_ready);
        end
        rose = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) rose = 1'b1;
        end
        n_cmp++;
        if (rose) begin
            n_bad++;
            $display("FAIL mid_rst_abort: out_valid rose=%b required 0", rose);
        end
        run_vec(dc_vec(256), 1'b0, "mid_rst_next");
        consume("mid_rst_next");
    endtask

    task automatic test_sat();
        vec_t x;
        for (int k = 0; k < 8; k++) x[k] = (cval(0, k) >= 0) ? 32'sh7FFFFFFF : -32'sh7FFFFFFF;
        run_vec(x, 1'b0, "sat");
`ifdef IDCT8_SAT_EN
        n_cmp++;
        if (dout[0] !== 32'sh7FFFFFFF) begin
            n_bad++;
            $display("FAIL sat_out0: got %h required 7fffffff", dout[0]);
        end
`endif
        consume("sat");
    endtask

    task automatic test_in_change();
        for (int t = 0; t < 3; t++) begin
            run_vec(rand_vec(1'b0), 1'b1, $sformatf("churn%0d", t));
            consume($sformatf("churn%0d", t));
        end
    endtask

    task automatic test_back_to_back();
        vec_t a;
        a = rand_vec(1'b1);
        run_vec(a, 1'b0, "b2b_a");
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        run_vec(rand_vec(1'b0), 1'b0, "b2b_b");
        consume("b2b_b");
    endtask

    initial begin
        test_reset();
        test_dc();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_sat();
        test_in_change();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
